// File: rtl/block_memory_pkg.sv
// Shared definitions for the block memory controller.
// Holds the fixed cell locations of the config/status words and the clear FSM state type.
package block_memory_pkg;

  localparam int CONFIG_ADDR = 0;
  localparam int STATUS_ADDR = 1;

  typedef enum logic {
    CLEAR,
    IDLE
  } clear_state_t;

endpackage

// File: rtl/mem_clear_ctrl.sv
// Clear sequencer for block_memory_ctrl.
// Walks a pointer over the whole memory, one access-width group of cells per cycle,
// and reports busy until the last group has been zeroed. Reset restarts from cell 0.
module mem_clear_ctrl #(
  parameter int size     = 1024,
  parameter int log_size = 10,
  parameter int blocks   = 4
) (
  input  logic                in_clk,
  input  logic                in_reset,
  output logic                out_busy,
  output logic [log_size-1:0] out_pointer
);
  import block_memory_pkg::*;

  localparam logic [log_size-1:0] last_ptr = log_size'(size - blocks);
  localparam logic [log_size-1:0] step     = log_size'(blocks);

  clear_state_t        state;
  clear_state_t        next_state;
  logic [log_size-1:0] pointer;

  // State register and clear pointer; the pointer only advances while clearing.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state   <= CLEAR;
      pointer <= '0;
    end else begin
      state <= next_state;
      if (state == CLEAR) begin
        pointer <= pointer + step;
      end
    end
  end

  // Leave CLEAR once the final group has been zeroed; busy covers every clearing cycle.
  always_comb begin
    next_state = state;
    out_busy   = 1'b0;
    case (state)
      CLEAR: begin
        out_busy = 1'b1;
        if (pointer == last_ptr) begin
          next_state = IDLE;
        end
      end
      IDLE:    next_state = IDLE;
      default: next_state = CLEAR;
    endcase
  end

  assign out_pointer = pointer;

endmodule

// File: rtl/block_memory_ctrl.sv
// Multi-cell operand/result store for the coprocessor.
// Each access touches blocks consecutive cells starting at any cell address. Cells are
// interleaved over blocks banks (bank = cell % blocks), so every access hits each bank
// exactly once and each bank needs only one read and one write port.
// Optional build macro: MEM_CELL_MASK_EN adds in_mask for per-cell write enables.
module block_memory_ctrl #(
  parameter  int size       = 1024,
  parameter  int log_size   = 10,
  parameter  int blocks     = 4,
  parameter  int cell_width = 32,
  localparam int width      = blocks * cell_width
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic                  in_req_valid,
  output logic                  out_req_ready,
  input  logic                  in_write,
  input  logic [log_size-1:0]   in_address,
  input  logic [width-1:0]      in_data,
`ifdef MEM_CELL_MASK_EN
  input  logic [blocks-1:0]     in_mask,
`endif
  input  logic [cell_width-1:0] in_status,
  input  logic                  in_write_status_en,
  output logic                  out_rd_valid,
  output logic [width-1:0]      out_data,
  output logic [cell_width-1:0] out_status,
  output logic [cell_width-1:0] out_config,
  output logic                  out_error,
  output logic                  out_busy
);
  import block_memory_pkg::*;

  localparam int rows       = size / blocks;
  localparam int row_w      = (rows > 1) ? $clog2(rows) : 1;
  localparam int cfg_bank_i = CONFIG_ADDR % blocks;
  localparam int sts_bank_i = STATUS_ADDR % blocks;
  localparam logic [row_w-1:0]    cfg_row  = row_w'(CONFIG_ADDR / blocks);
  localparam logic [row_w-1:0]    sts_row  = row_w'(STATUS_ADDR / blocks);
  localparam logic [log_size-1:0] blk_cnt  = log_size'(blocks);
  localparam logic [log_size:0]   last_off = (log_size + 1)'(blocks - 1);
  localparam logic [log_size:0]   last_idx = (log_size + 1)'(size - 1);

  logic                  busy;
  logic [log_size-1:0]   clr_pointer;
  logic [row_w-1:0]      clr_row;
  logic                  accept;
  logic                  in_range;
  logic [log_size:0]     end_addr;
  logic                  wr_en;
  logic                  sts_en;
  logic                  clr_en;
  logic [log_size-1:0]   base_row;
  logic [log_size-1:0]   phase;
  logic [blocks-1:0]     wr_mask;
  logic [width-1:0]      rd_word;
  logic [cell_width-1:0] rd_cell  [blocks];
  logic [log_size-1:0]   bank_off [blocks];

  mem_clear_ctrl #(
    .size     (size),
    .log_size (log_size),
    .blocks   (blocks)
  ) u_clear (
    .in_clk      (in_clk),
    .in_reset    (in_reset),
    .out_busy    (busy),
    .out_pointer (clr_pointer)
  );

  assign out_busy      = busy;
  assign out_req_ready = ~busy;
  assign accept        = in_req_valid & out_req_ready;

  assign end_addr = {1'b0, in_address} + last_off;
  assign in_range = (end_addr <= last_idx);

  assign wr_en  = accept & in_write & in_range & ~in_reset;
  assign sts_en = in_write_status_en & ~busy & ~in_reset;
  assign clr_en = busy & ~in_reset;

  assign base_row = in_address / blk_cnt;
  assign phase    = in_address % blk_cnt;
  assign clr_row  = row_w'(clr_pointer / blk_cnt);

`ifdef MEM_CELL_MASK_EN
  assign wr_mask = in_mask;
`else
  assign wr_mask = '1;
`endif

  for (genvar b = 0; b < blocks; b++) begin : g_bank
    localparam logic [log_size-1:0] bidx = log_size'(b);

    logic [cell_width-1:0] cells [rows];
    logic                  hit_low;
    logic [row_w-1:0]      row;
    logic [log_size-1:0]   off;
    logic                  mask_bit;
    logic [cell_width-1:0] wdata;

    assign hit_low  = (bidx >= phase);
    assign row      = hit_low ? row_w'(base_row) : row_w'(base_row + log_size'(1));
    assign off      = hit_low ? (bidx - phase) : (bidx + blk_cnt - phase);
    assign mask_bit = |(wr_mask & (blocks'(1) << off));
    assign wdata    = cell_width'(in_data >> (32'(off) * cell_width));

    assign rd_cell[b]  = cells[row];
    assign bank_off[b] = off;

    if (b == cfg_bank_i) begin : g_cfg
      assign out_config = cells[cfg_row];
    end
    if (b == sts_bank_i) begin : g_sts
      assign out_status = cells[sts_row];
    end

    // Bank write port: clearing has priority; a status update is applied after the data
    // write so it overrides the data port for the status cell.
    always_ff @(posedge in_clk) begin
      if (clr_en) begin
        cells[clr_row] <= '0;
      end else begin
        if (wr_en && mask_bit) begin
          cells[row] <= wdata;
        end
        if ((b == sts_bank_i) && sts_en) begin
          cells[sts_row] <= in_status;
        end
      end
    end
  end

  // Rotate the per-bank cells back into request order (slot 0 = first cell addressed).
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < blocks; i++) begin
      rd_word = rd_word | (width'(rd_cell[i]) << (32'(bank_off[i]) * cell_width));
    end
  end

  // Registered read response and error pulse; out_data holds between reads.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      out_rd_valid <= 1'b0;
      out_error    <= 1'b0;
      out_data     <= '0;
    end else begin
      out_rd_valid <= accept & ~in_write;
      out_error    <= accept & ~in_range;
      if (accept && !in_write) begin
        out_data <= in_range ? rd_word : '0;
      end
    end
  end

endmodule

// File: tb/tb_block_memory_ctrl.sv
// Testbench for block_memory_ctrl (default parameters).
// Define MEM_CELL_MASK_EN on both RTL and bench to exercise the masked-write port.
module tb_block_memory_ctrl;

  logic         in_clk;
  logic         in_reset;
  logic         in_req_valid;
  logic         out_req_ready;
  logic         in_write;
  logic [9:0]   in_address;
  logic [127:0] in_data;
`ifdef MEM_CELL_MASK_EN
  logic [3:0]   in_mask;
`endif
  logic [31:0]  in_status;
  logic         in_write_status_en;
  logic         out_rd_valid;
  logic [127:0] out_data;
  logic [31:0]  out_status;
  logic [31:0]  out_config;
  logic         out_error;
  logic         out_busy;

  typedef struct {
    logic         valid;
    logic         write;
    logic [9:0]   addr;
    logic [127:0] data;
    logic         sts_en;
    logic [31:0]  sts;
    logic         exp_err;
    logic [127:0] exp_data;
    logic [31:0]  exp_cfg;
    logic [31:0]  exp_sts;
  } vec_t;

  typedef struct {
    logic         is_read;
    logic         err;
    logic [127:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   passed;
  int   total;

  block_memory_ctrl dut (
    .in_clk             (in_clk),
    .in_reset           (in_reset),
    .in_req_valid       (in_req_valid),
    .out_req_ready      (out_req_ready),
    .in_write           (in_write),
    .in_address         (in_address),
    .in_data            (in_data),
`ifdef MEM_CELL_MASK_EN
    .in_mask            (in_mask),
`endif
    .in_status          (in_status),
    .in_write_status_en (in_write_status_en),
    .out_rd_valid       (out_rd_valid),
    .out_data           (out_data),
    .out_status         (out_status),
    .out_config         (out_config),
    .out_error          (out_error),
    .out_busy           (out_busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  // Hard stop in case something stalls the sequence below.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [127:0] pk(input logic [31:0] c3, input logic [31:0] c2,
                                      input logic [31:0] c1, input logic [31:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  function automatic vec_t mk(input logic valid, input logic write, input logic [9:0] addr,
                              input logic [127:0] data, input logic sts_en, input logic [31:0] sts,
                              input logic exp_err, input logic [127:0] exp_data,
                              input logic [31:0] exp_cfg, input logic [31:0] exp_sts);
    vec_t v;
    v.valid    = valid;
    v.write    = write;
    v.addr     = addr;
    v.data     = data;
    v.sts_en   = sts_en;
    v.sts      = sts;
    v.exp_err  = exp_err;
    v.exp_data = exp_data;
    v.exp_cfg  = exp_cfg;
    v.exp_sts  = exp_sts;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    @(negedge in_clk);
  endtask

  // Compare the response produced by the last edge against the oldest scoreboard entry.
  task automatic check_output();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rd_valid", 128'(out_rd_valid), 128'(e.is_read));
      check("error", 128'(out_error), 128'(e.err));
      if (e.is_read) begin
        check("rd_data", out_data, e.data);
      end
    end else begin
      check("idle_rd_valid", 128'(out_rd_valid), 128'(0));
      check("idle_error", 128'(out_error), 128'(0));
    end
  endtask

  // Drive one cycle of request from a vector, then check the response and fixed-cell views.
  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    if (v.valid) begin
      check("req_ready", 128'(out_req_ready), 128'(1));
    end
    in_req_valid       = v.valid;
    in_write           = v.write;
    in_address         = v.addr;
    in_data            = v.data;
    in_write_status_en = v.sts_en;
    in_status          = v.sts;
    if (v.valid) begin
      e.is_read = ~v.write;
      e.err     = v.exp_err;
      e.data    = v.exp_data;
      sb.push_back(e);
    end
    tick();
    check_output();
    check("config", 128'(out_config), 128'(v.exp_cfg));
    check("status", 128'(out_status), 128'(v.exp_sts));
    in_req_valid       = 1'b0;
    in_write_status_en = 1'b0;
  endtask

  // Count clearing cycles after reset release; the cycle following the reset edge is the first.
  task automatic count_busy(output int n, output logic stray_rd, output logic ready_seen);
    n          = 1;
    stray_rd   = 1'b0;
    ready_seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (out_rd_valid) stray_rd = 1'b1;
      if (!out_busy) break;
      if (out_req_ready) ready_seen = 1'b1;
      n++;
    end
  endtask

  initial begin
    int   n;
    logic stray;
    logic rdy;

    passed             = 0;
    total              = 0;
    in_reset           = 1'b1;
    in_req_valid       = 1'b0;
    in_write           = 1'b0;
    in_address         = '0;
    in_data            = '0;
    in_status          = '0;
    in_write_status_en = 1'b0;
`ifdef MEM_CELL_MASK_EN
    in_mask            = 4'hF;
`endif

    // Reset state and initial clear length.
    tick();
    check("rst_busy", 128'(out_busy), 128'(1));
    check("rst_ready", 128'(out_req_ready), 128'(0));
    check("rst_rd_valid", 128'(out_rd_valid), 128'(0));
    check("rst_error", 128'(out_error), 128'(0));
    check("rst_data", out_data, 128'(0));
    in_reset = 1'b0;
    count_busy(n, stray, rdy);
    check("clear_cycles", 128'(n), 128'(256));
    check("clear_ready_low", 128'(rdy), 128'(0));

    // valid, write, addr, data, sts_en, sts, exp_err, exp_data, exp_cfg, exp_sts
    vecs.push_back(mk(1, 0, 10'd8,    '0, 0, 0, 0, '0, 0, 0));
    vecs.push_back(mk(1, 0, 10'd1020, '0, 0, 0, 0, '0, 0, 0));
    vecs.push_back(mk(1, 1, 10'd8,    pk(4, 3, 2, 1), 0, 0, 0, '0, 0, 0));
    vecs.push_back(mk(1, 0, 10'd8,    '0, 0, 0, 0, pk(4, 3, 2, 1), 0, 0));
    vecs.push_back(mk(1, 0, 10'd1021, '0, 0, 0, 1, '0, 0, 0));
    vecs.push_back(mk(1, 1, 10'd1022, pk(9, 9, 9, 9), 0, 0, 1, '0, 0, 0));
    vecs.push_back(mk(1, 0, 10'd1020, '0, 0, 0, 0, '0, 0, 0));
    vecs.push_back(mk(1, 1, 10'd0,    pk(32'hD, 32'hC, 32'hB, 32'hA), 1, 5, 0, '0, 32'hA, 5));
    vecs.push_back(mk(1, 0, 10'd0,    '0, 0, 0, 0, pk(32'hD, 32'hC, 5, 32'hA), 32'hA, 5));
    vecs.push_back(mk(1, 1, 10'd6,    pk(8, 7, 6, 5), 0, 0, 0, '0, 32'hA, 5));
    vecs.push_back(mk(1, 0, 10'd7,    '0, 0, 0, 0, pk(3, 8, 7, 6), 32'hA, 5));
    vecs.push_back(mk(1, 0, 10'd1,    '0, 1, 32'h77, 0, pk(0, 32'hD, 32'hC, 5), 32'hA, 32'h77));
    vecs.push_back(mk(1, 0, 10'd1,    '0, 0, 0, 0, pk(0, 32'hD, 32'hC, 32'h77), 32'hA, 32'h77));
    vecs.push_back(mk(0, 0, 10'd0,    '0, 0, 0, 0, '0, 32'hA, 32'h77));
    vecs.push_back(mk(1, 0, 10'd3,    '0, 0, 0, 0, pk(5, 0, 0, 32'hD), 32'hA, 32'h77));
    vecs.push_back(mk(1, 1, 10'd1,    pk(32'h11, 32'h22, 32'h33, 32'h44), 1, 32'h99, 0, '0,
                      32'hA, 32'h99));
    vecs.push_back(mk(1, 0, 10'd0,    '0, 0, 0, 0, pk(32'h22, 32'h33, 32'h99, 32'hA),
                      32'hA, 32'h99));
    vecs.push_back(mk(1, 0, 10'd4,    '0, 0, 0, 0, pk(6, 5, 0, 32'h11), 32'hA, 32'h99));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
    end

`ifdef MEM_CELL_MASK_EN
    // Masked write: only cells 16 and 18 take the new value.
    apply_stimulus(mk(1, 1, 10'd16, pk(4, 3, 2, 1), 0, 0, 0, '0, 32'hA, 32'h99));
    in_mask = 4'b0101;
    apply_stimulus(mk(1, 1, 10'd16, pk(32'hF, 32'hF, 32'hF, 32'hF), 0, 0, 0, '0, 32'hA, 32'h99));
    in_mask = 4'hF;
    apply_stimulus(mk(1, 0, 10'd16, '0, 0, 0, 0, pk(4, 32'hF, 2, 32'hF), 32'hA, 32'h99));
`endif

    // Reset from IDLE: outputs return to reset values and clearing starts.
    in_reset = 1'b1;
    tick();
    check("rst2_data", out_data, 128'(0));
    check("rst2_busy", 128'(out_busy), 128'(1));
    in_reset = 1'b0;
    for (int k = 0; k < 99; k++) begin
      tick();
    end
    check("busy_mid_clear", 128'(out_busy), 128'(1));

    // Reset again at clear cycle 100, with requests and status writes held during the clear.
    in_reset = 1'b1;
    tick();
    in_reset           = 1'b0;
    in_req_valid       = 1'b1;
    in_write           = 1'b1;
    in_address         = 10'd8;
    in_data            = pk(32'hFF, 32'hFF, 32'hFF, 32'hFF);
    in_write_status_en = 1'b1;
    in_status          = 32'hEE;
    count_busy(n, stray, rdy);
    in_req_valid       = 1'b0;
    in_write_status_en = 1'b0;
    check("restart_clear_cycles", 128'(n), 128'(256));
    check("no_rd_in_clear", 128'(stray), 128'(0));
    check("restart_ready_low", 128'(rdy), 128'(0));
    check("cleared_status", 128'(out_status), 128'(0));
    check("cleared_config", 128'(out_config), 128'(0));
    apply_stimulus(mk(1, 0, 10'd8, '0, 0, 0, 0, '0, 0, 0));
    apply_stimulus(mk(1, 0, 10'd0, '0, 0, 0, 0, '0, 0, 0));
    apply_stimulus(mk(0, 0, 10'd0, '0, 0, 0, 0, '0, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
